q_secant_sequencer: RTL

Q_SECANT_SEQUENCER -- requirements
Module: q_secant_sequencer

---
 rtl/q_secant_sequencer_if.sv | 23 ++
 rtl/q_secant_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/q_secant_sequencer_if.sv
// Handshake bundle between the secant sequencer and the external step unit.
// master = sequencer (issues operands and request), slave = step unit (returns x_next).
interface q_secant_sequencer_if #(
    parameter int WIDTH = 10
);
    logic             calc_req;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] f0;
    logic [WIDTH-1:0] f1;
    logic             calc_ack;
    logic [WIDTH-1:0] x_next;

    modport master (
        output calc_req, x0, x1, f0, f1,
        input  calc_ack, x_next
    );

    modport slave (
        input  calc_req, x0, x1, f0, f1,
        output calc_ack, x_next
    );
endinterface

// File: rtl/q_secant_sequencer.sv
// Secant-method charge solver: drives i_ref, waits for the plant to settle, samples q_meas
// and asks an external step unit for the next current. Define Q_SECANT_CLAMP_EN to saturate x_next.
module q_secant_sequencer #(
    parameter int WIDTH         = 10,
    parameter int MAX_ITER      = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int TOL           = 2,
    parameter int X0_INIT       = 1,
    parameter int X1_INIT       = 11,
    parameter int I_MIN         = 0,
    parameter int I_MAX         = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           desired_q,
    input  logic [WIDTH-1:0]           q_meas,
    output logic [WIDTH-1:0]           i_ref,
    q_secant_sequencer_if.master       step,
    output logic                       busy,
    output logic                       done,
    output logic                       fail,
    output logic [WIDTH-1:0]           obt_q,
    output logic [4:0]                 iter_cnt
);
    localparam int W1    = WIDTH + 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [4:0]       MAX_ITER_C  = 5'(MAX_ITER);
    localparam logic [W1-1:0]    TOL_C       = W1'(TOL);
    localparam logic [WIDTH-1:0] X0_C        = WIDTH'(X0_INIT);
    localparam logic [WIDTH-1:0] X1_C        = WIDTH'(X1_INIT);
    localparam logic [WIDTH-1:0] I_MIN_C     = WIDTH'(I_MIN);
    localparam logic [WIDTH-1:0] I_MAX_C     = WIDTH'(I_MAX);

`ifdef Q_SECANT_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, APPLY0, SETTLE, SAMPLE, CALC, DONE} state_t;

    state_t           state_reg,   state_next;
    logic [WIDTH-1:0] desired_reg, desired_next;
    logic [WIDTH-1:0] x0_reg,      x0_next;
    logic [WIDTH-1:0] x1_reg,      x1_next;
    logic [WIDTH-1:0] f0_reg,      f0_next;
    logic [WIDTH-1:0] f1_reg,      f1_next;
    logic [WIDTH-1:0] i_ref_reg,   i_ref_next;
    logic [WIDTH-1:0] obt_reg,     obt_next;
    logic [4:0]       iter_reg,    iter_next;
    logic [CNT_W-1:0] settle_reg,  settle_next;
    logic             seed_reg,    seed_next;
    logic             done_reg,    done_next;
    logic             fail_reg,    fail_next;

    logic [W1-1:0]    q_ext;
    logic [W1-1:0]    d_ext;
    logic [W1-1:0]    err;
    logic             converged;
    logic [WIDTH-1:0] x_load;

    // Error magnitude carries one extra bit so it never wraps.
    assign q_ext     = {1'b0, q_meas};
    assign d_ext     = {1'b0, desired_reg};
    assign err       = (q_ext >= d_ext) ? (q_ext - d_ext) : (d_ext - q_ext);
    assign converged = (err <= TOL_C);

    always_comb begin
        x_load = step.x_next;
        if (CLAMP_EN) begin
            if (step.x_next <= I_MIN_C)
                x_load = I_MIN_C;
            else if (step.x_next >= I_MAX_C)
                x_load = I_MAX_C;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            desired_reg <= '0;
            x0_reg      <= '0;
            x1_reg      <= '0;
            f0_reg      <= '0;
            f1_reg      <= '0;
            i_ref_reg   <= '0;
            obt_reg     <= '0;
            iter_reg    <= '0;
            settle_reg  <= '0;
            seed_reg    <= 1'b0;
            done_reg    <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            desired_reg <= desired_next;
            x0_reg      <= x0_next;
            x1_reg      <= x1_next;
            f0_reg      <= f0_next;
            f1_reg      <= f1_next;
            i_ref_reg   <= i_ref_next;
            obt_reg     <= obt_next;
            iter_reg    <= iter_next;
            settle_reg  <= settle_next;
            seed_reg    <= seed_next;
            done_reg    <= done_next;
            fail_reg    <= fail_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        desired_next = desired_reg;
        x0_next      = x0_reg;
        x1_next      = x1_reg;
        f0_next      = f0_reg;
        f1_next      = f1_reg;
        i_ref_next   = i_ref_reg;
        obt_next     = obt_reg;
        iter_next    = iter_reg;
        settle_next  = settle_reg;
        seed_next    = seed_reg;
        done_next    = done_reg;
        fail_next    = fail_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    desired_next = desired_q;
                    x0_next      = X0_C;
                    x1_next      = X1_C;
                    iter_next    = '0;
                    done_next    = 1'b0;
                    fail_next    = 1'b0;
                    state_next   = APPLY0;
                end
            end
            APPLY0: begin
                i_ref_next  = x0_reg;
                settle_next = '0;
                seed_next   = 1'b1;
                state_next  = SETTLE;
            end
            SETTLE: begin
                if (settle_reg == SETTLE_LAST)
                    state_next = SAMPLE;
                else
                    settle_next = settle_reg + CNT_W'(1);
            end
            SAMPLE: begin
                if (seed_reg) begin
                    // First sample belongs to x0; now measure at x1.
                    f0_next     = q_meas;
                    seed_next   = 1'b0;
                    i_ref_next  = x1_reg;
                    settle_next = '0;
                    state_next  = SETTLE;
                end else begin
                    f1_next  = q_meas;
                    obt_next = q_meas;
                    if (converged) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else if (iter_reg == MAX_ITER_C) begin
                        fail_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (f0_reg == f1_reg) begin
                    // Flat secant: the step would divide by zero.
                    fail_next  = 1'b1;
                    state_next = DONE;
                end else if (step.calc_ack) begin
                    x0_next     = x1_reg;
                    f0_next     = f1_reg;
                    x1_next     = x_load;
                    i_ref_next  = x_load;
                    iter_next   = iter_reg + 5'd1;
                    settle_next = '0;
                    state_next  = SETTLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy          = (state_reg != IDLE) && (state_reg != DONE);
    assign step.calc_req = (state_reg == CALC) && (f0_reg != f1_reg);
    assign step.x0       = x0_reg;
    assign step.x1       = x1_reg;
    assign step.f0       = f0_reg;
    assign step.f1       = f1_reg;
    assign i_ref         = i_ref_reg;
    assign done          = done_reg;
    assign fail          = fail_reg;
    assign obt_q         = obt_reg;
    assign iter_cnt      = iter_reg;
endmodule
